// File: rtl/buf_fifo.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
// Arbitrary DEPTH (not only powers of two); every output is a flop.
module buf_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_inc, rd_ptr_inc;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push, pop;

  // Handshakes use only registered flags, so no in->out combinational path.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_inc = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
    rd_ptr_inc = (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    head_nxt   = '0;
    if (clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr_inc;
      if (pop)  rd_ptr_nxt = rd_ptr_inc;
      if (push && !pop)      count_nxt = count + CW'(1);
      else if (pop && !push) count_nxt = count - CW'(1);
    end
    // A word written this cycle becomes the head only when it is the sole word left.
    if (count_nxt != '0) begin
      if (!clr && push && count_nxt == CW'(1)) head_nxt = in_data;
      else                                    head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      empty     <= (count_nxt == '0);
      in_ready  <= (count_nxt != CW'(DEPTH));
      out_valid <= (count_nxt != '0);
      out_data  <= head_nxt;
    end
  end

  // Storage is deliberately not reset; empty forces out_data to zero instead.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= in_data;
  end

endmodule
